// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter for the IJVM datapath.
//
// Holds the PC and updates it on the rising edge from one of three sources,
// in priority order:
//   1. a load from the C bus,
//   2. a relative branch (two's-complement offset, wraps),
//   3. an increment by INC_STEP, requested by `inc`, by a completed fetch, or
//      by both. When both ask in the same cycle the PC moves by INC_STEP once.
// The PC is copied onto the tri-state B bus on the falling edge. A small
// two-state fetch FSM issues a valid/ready request to memory at the current
// PC and asks for an increment when the memory accepts it.
//
// Optional feature: define PC_OVF_DETECT_EN to enable the sticky wrap flag
// pc_ovf. When the macro is undefined pc_ovf is tied low and the carry logic
// is not built.
//
// Ports:
//   clk            in   system clock (posedge state, negedge B bus)
//   rst            in   asynchronous active-high reset
//   c_bus          in   value loaded into the PC when c_write_enable is high
//   c_write_enable in   load the PC from c_bus
//   b_read_enable  in   drive the PC onto b_bus at the next falling edge
//   b_bus          out  tri-state B bus
//   branch_en      in   add branch_offset to the PC
//   branch_offset  in   two's-complement relative offset
//   inc            in   add INC_STEP to the PC
//   fetch_req      in   start an instruction fetch at the current PC
//   mem_addr       out  fetch address latched at fetch start
//   mem_valid      out  fetch request outstanding
//   mem_ready      in   memory accepts the fetch
//   fetch_busy     out  fetch FSM is waiting on memory
//   pc_value       out  current PC
//   pc_ovf         out  sticky wrap flag
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned            WORD_WIDTH   = 8,
  parameter logic [WORD_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            INC_STEP     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] c_bus,
  input  logic                  c_write_enable,
  input  logic                  b_read_enable,
  output logic [WORD_WIDTH-1:0] b_bus,
  input  logic                  branch_en,
  input  logic [WORD_WIDTH-1:0] branch_offset,
  input  logic                  inc,
  input  logic                  fetch_req,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  fetch_busy,
  output logic [WORD_WIDTH-1:0] pc_value,
  output logic                  pc_ovf
);

  localparam logic [WORD_WIDTH-1:0] INC_W = WORD_WIDTH'(INC_STEP);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q;
  logic [WORD_WIDTH-1:0]   pc_q, pc_d;
  logic [WORD_WIDTH-1:0]   inc_res, br_res;
  logic [WORD_WIDTH-1:0]   mem_addr_q;
  logic                    mem_valid_q;
  logic [WORD_WIDTH-1:0]   b_data_q;
  logic                    b_en_q;
  logic                    fetch_done;

  // The handshake completes on the edge where valid and ready are both high.
  assign fetch_done = (state_q == S_WAIT) && mem_valid_q && mem_ready;

`ifdef PC_OVF_DETECT_EN
  // Unsigned add that keeps the carry out in the top bit.
  function automatic logic [WORD_WIDTH:0] add_carry(input logic [WORD_WIDTH-1:0] a,
                                                    input logic [WORD_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [WORD_WIDTH:0] inc_sum, br_sum;
  logic                ovf_event;
  logic                pc_ovf_q;

  assign inc_sum = add_carry(pc_q, INC_W);
  assign br_sum  = add_carry(pc_q, branch_offset);
  assign inc_res = inc_sum[WORD_WIDTH-1:0];
  assign br_res  = br_sum[WORD_WIDTH-1:0];

  // A positive offset wraps on carry out; a negative offset (added as its
  // two's complement) wraps below zero exactly when there is no carry out.
  always_comb begin
    ovf_event = 1'b0;
    if (!c_write_enable) begin
      if (branch_en)
        ovf_event = branch_offset[WORD_WIDTH-1] ? ~br_sum[WORD_WIDTH] : br_sum[WORD_WIDTH];
      else if (inc || fetch_done)
        ovf_event = inc_sum[WORD_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc_ovf_q <= 1'b0;
    else if (ovf_event) pc_ovf_q <= 1'b1;
  end

  assign pc_ovf = pc_ovf_q;
`else
  assign inc_res = pc_q + INC_W;
  assign br_res  = pc_q + branch_offset;
  assign pc_ovf  = 1'b0;
`endif

  // PC next state; a load or branch swallows any increment in the same cycle.
  always_comb begin
    pc_d = pc_q;
    if (c_write_enable)           pc_d = c_bus;
    else if (branch_en)           pc_d = br_res;
    else if (inc || fetch_done)   pc_d = inc_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_req) begin
            mem_addr_q  <= pc_q;
            mem_valid_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fetch_done) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          mem_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // B bus is captured on the falling edge so it carries the PC registered at
  // the preceding rising edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      b_en_q   <= 1'b0;
      b_data_q <= '0;
    end else begin
      b_en_q   <= b_read_enable;
      b_data_q <= pc_q;
    end
  end

  assign b_bus      = b_en_q ? b_data_q : {WORD_WIDTH{1'bz}};
  assign mem_addr   = mem_addr_q;
  assign mem_valid  = mem_valid_q;
  assign fetch_busy = (state_q == S_WAIT);
  assign pc_value   = pc_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the IJVM datapath.
- Holds the PC and drives it onto the tri-state B bus on the falling clock edge.
- Loads it from the C bus, and can also do a relative branch or a plain increment.
- Runs its own instruction-fetch handshake to memory, with auto-increment when each fetch completes.

Parameters:
- WORD_WIDTH, 8, width of the PC, C bus, B bus, branch offset and memory address.
- RESET_VECTOR, 0, PC value loaded on reset.
- INC_STEP, 1, amount added to the PC on an increment or a completed fetch (unsigned, < 2^WORD_WIDTH).

Ports:
- clk  input  1  system clock; all state changes on posedge, except b_bus, which updates on negedge.
- rst  input  1  reset, asynchronous, active-high.
- c_bus  input  WORD_WIDTH  value to load into the PC.
- c_write_enable  input  1  load the PC from c_bus.
- b_read_enable  input  1  drive the PC onto b_bus.
- b_bus  output  WORD_WIDTH  tri-state B bus output.
- branch_en  input  1  add branch_offset to the PC.
- branch_offset  input  WORD_WIDTH  two's-complement relative offset.
- inc  input  1  add INC_STEP to the PC.
- fetch_req  input  1  start an instruction fetch at the current PC.
- mem_addr  output  WORD_WIDTH  fetch address, latched at fetch start.
- mem_valid  output  1  fetch request outstanding.
- mem_ready  input  1  memory accepts the fetch.
- fetch_busy  output  1  fetch FSM is not in IDLE.
- pc_value  output  WORD_WIDTH  current PC (registered, always visible).
- pc_ovf  output  1  sticky wrap flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - PC = RESET_VECTOR; FSM = IDLE.
  - mem_valid = 0, mem_addr = 0, fetch_busy = 0, pc_ovf = 0.
  - b_bus = Z.
- PC update on posedge clk, with priority c_write_enable > branch_en > (inc OR fetch completion):
  - c_write_enable: PC <= c_bus.
  - branch_en: PC <= PC + branch_offset, computed modulo 2^WORD_WIDTH (wraps).
  - inc or fetch completion: PC <= PC + INC_STEP, modulo 2^WORD_WIDTH. If both occur in the same cycle, the PC advances by INC_STEP once, not twice.
  - A higher-priority write suppresses any increment in the same cycle, including a fetch-completion increment.
- B bus on negedge clk:
  - b_read_enable = 1: b_bus <= the PC value registered at the preceding posedge.
  - Otherwise b_bus <= Z.
- Fetch FSM, two states:
  - IDLE: on fetch_req = 1, latch mem_addr <= PC (the pre-update value of that cycle), set mem_valid <= 1, go to WAIT. Otherwise stay.
  - WAIT: mem_valid = 1 and mem_addr held stable. When mem_valid & mem_ready are seen at a posedge, the fetch completes: mem_valid <= 0, go to IDLE, request the increment.
  - fetch_req is ignored in WAIT.
  - Earliest new fetch: fetch_req in the cycle after completion (one idle cycle minimum between fetches).
  - fetch_busy = (state == WAIT).
- Latency:
  - C-bus load, branch and increment are visible on pc_value one posedge after the request, and on b_bus at the following negedge.
  - mem_valid rises one posedge after fetch_req.
- c_write_enable or branch_en in WAIT:
  - PC updates immediately.
  - The outstanding fetch keeps its latched mem_addr.
  - Its completion increment is dropped only if it lands in the same cycle as the higher-priority write.

Optional Feature:
- Macro: PC_OVF_DETECT_EN.
- Defined: pc_ovf is set (sticky until rst) when any of these wraps past 2^WORD_WIDTH-1 or below 0:
  - an increment;
  - a fetch-completion increment;
  - a branch addition (signed overflow of the unsigned address space: carry for a positive offset, borrow for a negative one).
  - A C-bus load never sets it.
- Not defined: pc_ovf is tied to 0 and the detection logic is absent. Wrap-around arithmetic is unchanged.

Test Plan:
- Reset with RESET_VECTOR=8'h10, then assert b_read_enable → pc_value=0x10; b_bus=0x10 after the negedge; b_bus=Z when b_read_enable is low.
- Pulse c_write_enable with c_bus=0x3C, holding branch_en and inc high in the same cycle → PC=0x3C (write wins).
- From PC=0x20, pulse fetch_req; mem_ready low for 2 cycles, then high → mem_addr=0x20 with mem_valid high for 3 cycles, fetch_busy high throughout, PC=0x21 after completion.
- From PC=0x05, branch_en with offset 0xFE (-2) → PC=0x03. From PC=0xFF, inc → PC=0x00 and, with PC_OVF_DETECT_EN, pc_ovf=1 and held.
- During WAIT at mem_addr=0x40, pulse c_write_enable with c_bus=0x80 in the same cycle as mem_ready → mem_addr stays 0x40, PC=0x80 (no increment), FSM returns to IDLE.
- Assert rst asynchronously mid-WAIT → mem_valid, fetch_busy and pc_ovf go to 0 and PC to RESET_VECTOR immediately, without waiting for a clock edge.
